// File: rtl/mpadd_pkg.sv
// Shared word width and FSM state encoding for the multi-precision add/sub sequencer.
package mpadd_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/add_rca_32_bit.sv
// 32-bit ripple-carry adder: combinational sum and carry-out from x, y and carry-in.
module add_rca_32_bit (
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  input  logic        i_ci,
  output logic [31:0] o_sum,
  output logic        o_co
);
  logic v_carry;

  always_comb begin
    v_carry = i_ci;
    o_sum   = '0;
    for (int i = 0; i < 32; i++) begin
      o_sum[i] = i_x[i] ^ i_y[i] ^ v_carry;
      v_carry  = (i_x[i] & i_y[i]) | (v_carry & (i_x[i] ^ i_y[i]));
    end
    o_co = v_carry;
  end
endmodule

// File: rtl/add_mp_seq.sv
// Multi-precision add/subtract sequencer: one 32-bit word per cycle through add_rca_32_bit,
// LS word first. Define MPADD_SUB_EN to enable subtraction (sub input otherwise ignored).
module add_mp_seq
  import mpadd_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sub,
  input  logic [WORDS*WORD_W-1:0] a,
  input  logic [WORDS*WORD_W-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [WORDS*WORD_W-1:0] result,
  output logic                    co,
  output logic                    ovf
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  // Handshake: start is taken on any rising edge where busy==0 (IDLE or DONE);
  // done pulses for one cycle and result/co/ovf are valid from then until the next accept.
  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [WORD_W-1:0]   r_a      [WORDS];
  logic [WORD_W-1:0]   r_b      [WORDS];
  logic [WORD_W-1:0]   r_result [WORDS];
  logic                r_carry;
  logic                r_co;
  logic                r_ovf;
  logic                r_busy;
  logic                r_done;

  logic [WORD_W-1:0]   w_x;
  logic [WORD_W-1:0]   w_y;
  logic [WORD_W-1:0]   w_sum;
  logic                w_co;
  logic                w_sub_in;

  assign w_x = r_a[r_idx];

`ifdef MPADD_SUB_EN
  logic r_sub;
  assign w_sub_in = sub;
  assign w_y      = r_b[r_idx] ^ {WORD_W{r_sub}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sub <= 1'b0;
    else if (start && !r_busy)
      r_sub <= sub;
  end
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_sub_in     = 1'b0;
  assign w_y          = r_b[r_idx];
`endif

  add_rca_32_bit u_add (
    .i_x   (w_x),
    .i_y   (w_y),
    .i_ci  (r_carry),
    .o_sum (w_sum),
    .o_co  (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        r_a[i]      <= '0;
        r_b[i]      <= '0;
        r_result[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            for (int i = 0; i < WORDS; i++) begin
              r_a[i] <= a[i*WORD_W +: WORD_W];
              r_b[i] <= b[i*WORD_W +: WORD_W];
            end
            r_idx   <= '0;
            r_carry <= w_sub_in;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_result[r_idx] <= w_sum;
          r_carry         <= w_co;
          r_idx           <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            // Overflow judged on the MS word with the (possibly inverted) B operand.
            r_co    <= w_co;
            r_ovf   <= (w_x[WORD_W-1] == w_y[WORD_W-1]) && (w_sum[WORD_W-1] != w_x[WORD_W-1]);
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_result
    assign result[g*WORD_W +: WORD_W] = r_result[g];
  end

  assign busy = r_busy;
  assign done = r_done;
  assign co   = r_co;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_add_mp_seq.sv
// Randomized scoreboard bench for add_mp_seq (WORDS=4) against a full-width arithmetic model.
module tb_add_mp_seq;
  localparam int WORDS = 4;
  localparam int W     = WORDS * 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         co;
  logic         ovf;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [W+1:0] exp_q[$];
  int           lat_q[$];

  add_mp_seq #(.WORDS(WORDS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .co     (co),
    .ovf    (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Reference: {ovf, co, result} from whole-operand modular arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         se;
    logic         ov;
`ifdef MPADD_SUB_EN
    se = ms;
`else
    se = 1'b0;
`endif
    bb   = se ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, se};
    ov   = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return {ov, full};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   W'(busy),   '0);
    check({tag, "_done"},   W'(done),   '0);
    check({tag, "_result"}, result,     '0);
    check({tag, "_co"},     W'(co),     '0);
    check({tag, "_ovf"},    W'(ovf),    '0);
  endtask

  // driver
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input bit track);
    int waited = 0;
    @(negedge clk);
    while (busy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: busy still %0b after %0d cycles, expected 0", busy, waited);
      return;
    end
    a     = ta;
    b     = tb_v;
    sub   = ts;
    start = 1'b1;
    if (track) begin
      exp_q.push_back(model(ta, tb_v, ts));
      lat_q.push_back(cyc + 1 + WORDS);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = {$urandom, $urandom, $urandom, $urandom};
    b     = {$urandom, $urandom, $urandom, $urandom};
    sub   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_queue_empty", W'(exp_q.size()), '0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++)
      v[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    return v;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with no outstanding request", cyc);
      end else begin
        logic [W+1:0] e;
        int           l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("result",       result,     e[W-1:0]);
        check("co",           W'(co),     W'(e[W]));
        check("ovf",          W'(ovf),    W'(e[W+1]));
        check("done_latency", W'(cyc),    W'(l));
        check("busy_at_done", W'(busy),   '0);
      end
    end
  end

  // stimulus
  initial begin
    logic [W-1:0] ones;
    ones  = '1;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    check_reset_outputs("reset_initial");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b1);
    issue(ones, 128'd1, 1'b0, 1'b1);
    issue({1'b0, ones[W-2:0]}, 128'd1, 1'b0, 1'b1);
    issue(128'd5, 128'd3, 1'b1, 1'b1);
    issue(128'd0, 128'd1, 1'b1, 1'b1);
    wait_drain();

    // start pulsed mid-RUN must be ignored
    issue(rand_operand(), rand_operand(), 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a     = rand_operand();
    b     = rand_operand();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // asynchronous reset mid-RUN, then restart
    issue(rand_operand(), rand_operand(), 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    issue(rand_operand(), rand_operand(), 1'b1, 1'b1);
    wait_drain();

    // back-to-back random traffic
    for (int i = 0; i < 512; i++)
      issue(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), 1'b1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
